// File: rtl/tank_bullet_controller.sv
// Single-bullet controller for one tank: spawn on fire, advance once per frame,
// despawn on hit, edge, or lifetime expiry, then enforce a cooldown before re-arming.
module tank_bullet_controller #(
    parameter int BULLET_SIZE     = 2,
    parameter int SPEED           = 4,
    parameter int SPAWN_OFF       = 12,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 479,
    parameter int LIFETIME_FRAMES = 120,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int PARK_XY         = 1000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [1:0] TankDir,
    input  logic       barrier_hit,
    input  logic       tank_hit,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic [9:0] Bullet_Size,
    output logic       bullet_active,
    output logic       shot_fired,
    output logic       score_pulse
);

    localparam int LW = $clog2(LIFETIME_FRAMES + 1);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

    state_t         state;
    logic           fire_pending;
    logic [LW-1:0]  life_cnt;
    logic [CW-1:0]  cool_cnt;
    logic [1:0]     dir_q;

    logic [10:0]    sx, sy, nx, ny;
    logic           spawn_ok, move_ok, life_end, park_now;

    // 11-bit position is legal when it did not wrap below zero and sits in [lo,hi]
    function automatic logic in_rng(input logic [10:0] v, input int lo, input int hi);
        return !v[10] && (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    assign Bullet_Size = 10'(BULLET_SIZE);

    // Spawn point and next-frame position, both in 11 bits so underflow shows in bit 10
    always_comb begin
        sx = {1'b0, TankX};
        sy = {1'b0, TankY};
        case (TankDir)
            2'b00:   sy = {1'b0, TankY} - 11'(SPAWN_OFF);
            2'b01:   sx = {1'b0, TankX} + 11'(SPAWN_OFF);
            2'b10:   sy = {1'b0, TankY} + 11'(SPAWN_OFF);
            default: sx = {1'b0, TankX} - 11'(SPAWN_OFF);
        endcase
        nx = {1'b0, BulletX};
        ny = {1'b0, BulletY};
        case (dir_q)
            2'b00:   ny = {1'b0, BulletY} - 11'(SPEED);
            2'b01:   nx = {1'b0, BulletX} + 11'(SPEED);
            2'b10:   ny = {1'b0, BulletY} + 11'(SPEED);
            default: nx = {1'b0, BulletX} - 11'(SPEED);
        endcase
        spawn_ok = in_rng(sx, X_MIN, X_MAX) && in_rng(sy, Y_MIN, Y_MAX);
        move_ok  = in_rng(nx, X_MIN, X_MAX) && in_rng(ny, Y_MIN, Y_MAX);
        life_end = (life_cnt == LW'(LIFETIME_FRAMES - 1));
        park_now = tank_hit || barrier_hit || life_end || !move_ok;
    end

    // Bullet FSM; all outputs registered, pulses default low every cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            BulletX       <= 10'(PARK_XY);
            BulletY       <= 10'(PARK_XY);
            bullet_active <= 1'b0;
            shot_fired    <= 1'b0;
            score_pulse   <= 1'b0;
            fire_pending  <= 1'b0;
            life_cnt      <= '0;
            cool_cnt      <= '0;
            dir_q         <= 2'b00;
        end else begin
            shot_fired  <= 1'b0;
            score_pulse <= 1'b0;
            // a fire request outside flight is remembered until the next IDLE tick
            if (fire && state != FLY) fire_pending <= 1'b1;
            if (frame_tick) begin
                case (state)
                    IDLE: begin
                        if (fire || fire_pending) begin
                            fire_pending <= 1'b0;
                            if (spawn_ok) begin
                                BulletX       <= sx[9:0];
                                BulletY       <= sy[9:0];
                                dir_q         <= TankDir;
                                life_cnt      <= '0;
                                bullet_active <= 1'b1;
                                shot_fired    <= 1'b1;
                                state         <= FLY;
                            end else begin
                                cool_cnt <= '0;
                                state    <= COOL;
                            end
                        end
                    end
                    FLY: begin
                        if (park_now) begin
                            // tank_hit takes priority, so score follows it directly
                            score_pulse   <= tank_hit;
                            BulletX       <= 10'(PARK_XY);
                            BulletY       <= 10'(PARK_XY);
                            bullet_active <= 1'b0;
                            cool_cnt      <= '0;
                            state         <= COOL;
                        end else begin
                            BulletX  <= nx[9:0];
                            BulletY  <= ny[9:0];
                            life_cnt <= life_cnt + LW'(1);
                        end
                    end
                    COOL: begin
                        if (cool_cnt == CW'(COOLDOWN_FRAMES - 1)) begin
                            cool_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            cool_cnt <= cool_cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
